// File: rtl/ltc2656_pkg.sv
// Shared definitions for the LTC2656 SPI driver: command codes, frame layout,
// controller state encoding and small elaboration-time helpers.
package ltc2656_pkg;

  // LTC2656 command nibbles and the broadcast address
  localparam logic [3:0] WRITE_N        = 4'h0;
  localparam logic [3:0] UPDATE_N       = 4'h1;
  localparam logic [3:0] WRITE_UPDATE_N = 4'h3;
  localparam logic [3:0] POWER_DOWN_N   = 4'h4;
  localparam logic [3:0] NOP            = 4'hF;
  localparam logic [3:0] ADDR_ALL       = 4'hF;

  // One command frame is {cmd, address, code}
  localparam int FRAME_BITS = 24;
  localparam int BIT_CNT_W  = 5;

  typedef logic [FRAME_BITS-1:0] frame_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_SCK_HI = 3'd2,
    S_SCK_LO = 3'd3,
    S_GAP    = 3'd4,
    S_LDAC   = 3'd5
  } state_t;

  function automatic frame_t pack_frame(input logic [3:0]  cmd,
                                        input logic [3:0]  channel,
                                        input logic [15:0] value);
    return {cmd, channel, value};
  endfunction

  // Used to size the shared phase timer from the largest timing parameter
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/ltc2656_phase_timer.sv
// Loadable down-counter shared by every timed phase of the SPI driver.
// Loading N-1 on the cycle a phase is entered makes tc assert on the
// phase's N-th cycle, so a phase of N cycles ends exactly on time.
module ltc2656_phase_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] cnt;

  // Count down towards zero and park there; a load always takes priority
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/ltc2656_spi_driver.sv
// Serialises one 24-bit LTC2656 command frame per dac_start strobe and
// stretches dac_ldac into a timed active-low LDAC pin pulse.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | nothing in flight, csn high, LDAC high
// S_SETUP  | csn low, first bit on SDI, SCK low for CLK_DIV cycles
// S_SCK_HI | SCK high for CLK_DIV cycles, DAC samples SDI on the rise
// S_SCK_LO | SCK low for CLK_DIV cycles, SDI moved to the next bit
// S_GAP    | csn high for CS_GAP cycles (rise cycle included)
// S_LDAC   | LDAC pin low for LDAC_CYCLES cycles
module ltc2656_spi_driver
  import ltc2656_pkg::*;
#(
  parameter int CLK_DIV     = 4,
  parameter int CS_GAP      = 8,
  parameter int LDAC_CYCLES = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [3:0]  dac_cmd,
  input  logic [3:0]  dac_channel,
  input  logic [15:0] dac_value,
  input  logic        dac_start,
  input  logic        dac_ldac,
  output logic        spi_csn,
  output logic        spi_sck,
  output logic        spi_sdi,
  output logic        dac_ldac_n,
  output logic        busy,
  output logic        frame_done,
  output logic        overrun
);

  localparam int CNT_W = $clog2(max3(CLK_DIV, CS_GAP, LDAC_CYCLES)) + 1;

  localparam logic [CNT_W-1:0]     DIV_LD   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0]     GAP_LD   = CNT_W'(CS_GAP - 1);
  localparam logic [CNT_W-1:0]     LDAC_LD  = CNT_W'(LDAC_CYCLES - 1);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_BITS - 1);

  state_t                 state;
  frame_t                 shreg;
  frame_t                 pend_frame;
  frame_t                 new_frame;
  logic                   pend_start;
  logic                   pend_ldac;
  logic [BIT_CNT_W-1:0]   bit_cnt;

  logic                   timer_load;
  logic [CNT_W-1:0]       timer_val;
  logic                   timer_tc;
  logic                   start_take;
  logic                   ldac_take;

  assign new_frame = pack_frame(dac_cmd, dac_channel, dac_value);

  ltc2656_phase_timer #(
    .W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .resetn   (resetn),
    .load     (timer_load),
    .load_val (timer_val),
    .tc       (timer_tc)
  );

  // Reload the shared timer on every phase transition, and flag when a
  // pending request is being consumed so a same-cycle request can refill it
  always_comb begin
    timer_load = 1'b0;
    timer_val  = '0;
    start_take = 1'b0;
    ldac_take  = 1'b0;
    case (state)
      S_IDLE: begin
        if (dac_start || pend_start) begin
          timer_load = 1'b1;
          timer_val  = DIV_LD;
        end else if (dac_ldac || pend_ldac) begin
          timer_load = 1'b1;
          timer_val  = LDAC_LD;
        end
      end
      S_SETUP, S_SCK_HI: begin
        if (timer_tc) begin
          timer_load = 1'b1;
          timer_val  = DIV_LD;
        end
      end
      S_SCK_LO: begin
        if (timer_tc) begin
          timer_load = 1'b1;
          timer_val  = (bit_cnt != '0) ? DIV_LD : GAP_LD;
        end
      end
      S_GAP: begin
        if (timer_tc) begin
          if (pend_ldac) begin
            timer_load = 1'b1;
            timer_val  = LDAC_LD;
            ldac_take  = 1'b1;
          end else if (pend_start) begin
            timer_load = 1'b1;
            timer_val  = DIV_LD;
            start_take = 1'b1;
          end
        end
      end
      S_LDAC: begin
        if (timer_tc && pend_start) begin
          timer_load = 1'b1;
          timer_val  = DIV_LD;
          start_take = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Main sequencer: frame serialisation, CS gap, LDAC pulse and the
  // one-deep pending start / pending LDAC bookkeeping
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= S_IDLE;
      shreg      <= '0;
      pend_frame <= '0;
      pend_start <= 1'b0;
      pend_ldac  <= 1'b0;
      bit_cnt    <= '0;
      spi_csn    <= 1'b1;
      spi_sck    <= 1'b0;
      spi_sdi    <= 1'b0;
      dac_ldac_n <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      overrun    <= 1'b0;

      case (state)
        S_IDLE: begin
          // A start left pending by a same-cycle request at the end of the
          // previous activity is still honoured from here
          if (dac_start || pend_start) begin
            shreg      <= dac_start ? new_frame : pend_frame;
            spi_sdi    <= dac_start ? new_frame[FRAME_BITS-1] : pend_frame[FRAME_BITS-1];
            bit_cnt    <= LAST_BIT;
            spi_csn    <= 1'b0;
            busy       <= 1'b1;
            pend_start <= 1'b0;
            overrun    <= dac_start && pend_start;
            if (dac_ldac) pend_ldac <= 1'b1;
            state      <= S_SETUP;
          end else if (dac_ldac || pend_ldac) begin
            dac_ldac_n <= 1'b0;
            busy       <= 1'b1;
            pend_ldac  <= 1'b0;
            state      <= S_LDAC;
          end
        end

        S_SETUP: begin
          if (timer_tc) begin
            spi_sck <= 1'b1;
            state   <= S_SCK_HI;
          end
        end

        S_SCK_HI: begin
          if (timer_tc) begin
            spi_sck <= 1'b0;
            if (bit_cnt != '0) begin
              shreg   <= {shreg[FRAME_BITS-2:0], 1'b0};
              spi_sdi <= shreg[FRAME_BITS-2];
            end
            state <= S_SCK_LO;
          end
        end

        S_SCK_LO: begin
          if (timer_tc) begin
            if (bit_cnt != '0) begin
              bit_cnt <= bit_cnt - 1'b1;
              spi_sck <= 1'b1;
              state   <= S_SCK_HI;
            end else begin
              spi_csn    <= 1'b1;
              frame_done <= 1'b1;
              state      <= S_GAP;
            end
          end
        end

        S_GAP: begin
          if (timer_tc) begin
            if (pend_ldac) begin
              dac_ldac_n <= 1'b0;
              pend_ldac  <= 1'b0;
              state      <= S_LDAC;
            end else if (pend_start) begin
              shreg      <= pend_frame;
              spi_sdi    <= pend_frame[FRAME_BITS-1];
              bit_cnt    <= LAST_BIT;
              spi_csn    <= 1'b0;
              pend_start <= 1'b0;
              state      <= S_SETUP;
            end else begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end
          end
        end

        S_LDAC: begin
          if (timer_tc) begin
            dac_ldac_n <= 1'b1;
            if (pend_start) begin
              shreg      <= pend_frame;
              spi_sdi    <= pend_frame[FRAME_BITS-1];
              bit_cnt    <= LAST_BIT;
              spi_csn    <= 1'b0;
              pend_start <= 1'b0;
              state      <= S_SETUP;
            end else begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end
          end
        end

        default: state <= S_IDLE;
      endcase

      // Requests arriving while busy are parked; these assignments come last
      // so a new request wins over the slot being emptied this cycle
      if (state != S_IDLE) begin
        if (dac_start) begin
          pend_frame <= new_frame;
          pend_start <= 1'b1;
          if (pend_start && !start_take) overrun <= 1'b1;
        end
        // A request during an LDAC pulse, or on the cycle one starts, merges into it
        if (dac_ldac && state != S_LDAC && !ldac_take) pend_ldac <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ltc2656_spi_driver.sv
// Self-checking bench for ltc2656_spi_driver. Two instances share stimulus:
// u_a with CLK_DIV=4 and u_b with CLK_DIV=1. Pin monitors reconstruct frames,
// CS timing and LDAC pulses; expectations come from the frame rules.
module tb_ltc2656_spi_driver;
  import ltc2656_pkg::*;

  localparam int DIV_A = 4;
  localparam int DIV_B = 1;
  localparam int GAP   = 8;
  localparam int LDC   = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [3:0]  dac_cmd = '0;
  logic [3:0]  dac_channel = '0;
  logic [15:0] dac_value = '0;
  logic        dac_start = 1'b0;
  logic        dac_ldac = 1'b0;

  logic a_csn, a_sck, a_sdi, a_ldn, a_busy, a_fd, a_ovr;
  logic b_csn, b_sck, b_sdi, b_ldn, b_busy, b_fd, b_ovr;

  always #5 clk = ~clk;

  ltc2656_spi_driver #(.CLK_DIV(DIV_A), .CS_GAP(GAP), .LDAC_CYCLES(LDC)) u_a (
    .clk(clk), .resetn(resetn), .dac_cmd(dac_cmd), .dac_channel(dac_channel),
    .dac_value(dac_value), .dac_start(dac_start), .dac_ldac(dac_ldac),
    .spi_csn(a_csn), .spi_sck(a_sck), .spi_sdi(a_sdi), .dac_ldac_n(a_ldn),
    .busy(a_busy), .frame_done(a_fd), .overrun(a_ovr));

  ltc2656_spi_driver #(.CLK_DIV(DIV_B), .CS_GAP(GAP), .LDAC_CYCLES(LDC)) u_b (
    .clk(clk), .resetn(resetn), .dac_cmd(dac_cmd), .dac_channel(dac_channel),
    .dac_value(dac_value), .dac_start(dac_start), .dac_ldac(dac_ldac),
    .spi_csn(b_csn), .spi_sck(b_sck), .spi_sdi(b_sdi), .dac_ldac_n(b_ldn),
    .busy(b_busy), .frame_done(b_fd), .overrun(b_ovr));

  logic [1:0] csn_v, sck_v, sdi_v, ldn_v, busy_v, fd_v, ovr_v;
  assign csn_v  = {b_csn, a_csn};
  assign sck_v  = {b_sck, a_sck};
  assign sdi_v  = {b_sdi, a_sdi};
  assign ldn_v  = {b_ldn, a_ldn};
  assign busy_v = {b_busy, a_busy};
  assign fd_v   = {b_fd, a_fd};
  assign ovr_v  = {b_ovr, a_ovr};

  // ---------------- pin monitors (sampled on the falling edge) ----------------
  int cyc = 0;
  always @(negedge clk) cyc <= cyc + 1;

  logic [23:0] bits [2];
  int cur_nb [2], low_cnt [2], cur_gap [2], rise_cyc [2], ld_cur [2];
  int nfr [2], nfall [2], fd_cnt [2], fd_bad [2], ovr_cnt [2], nld [2], overlap [2], busy_bad [2];
  logic [1:0] rise_valid = 2'b00;
  logic [1:0] prev_csn = 2'b11, prev_sck = 2'b00, prev_ldn = 2'b11;
  logic [23:0] fr_bits [2][64];
  int fr_nb [2][64], fr_len [2][64], fr_gap [2][64], ld_len [2][16], ld_after [2][16];

  for (genvar g = 0; g < 2; g++) begin : g_mon
    always @(negedge clk) begin
      prev_csn[g] <= csn_v[g];
      prev_sck[g] <= sck_v[g];
      prev_ldn[g] <= ldn_v[g];
      if (csn_v[g] === 1'b0) begin
        if (prev_csn[g] === 1'b1) begin
          low_cnt[g] <= 1;
          bits[g]    <= '0;
          cur_nb[g]  <= 0;
          nfall[g]   <= nfall[g] + 1;
          cur_gap[g] <= rise_valid[g] ? (cyc - rise_cyc[g]) : -1;
        end else begin
          low_cnt[g] <= low_cnt[g] + 1;
          if (sck_v[g] === 1'b1 && prev_sck[g] === 1'b0) begin
            bits[g]   <= {bits[g][22:0], sdi_v[g]};
            cur_nb[g] <= cur_nb[g] + 1;
          end
        end
      end else if (csn_v[g] === 1'b1 && prev_csn[g] === 1'b0) begin
        fr_bits[g][nfr[g] % 64] <= bits[g];
        fr_nb[g][nfr[g] % 64]   <= cur_nb[g];
        fr_len[g][nfr[g] % 64]  <= low_cnt[g];
        fr_gap[g][nfr[g] % 64]  <= cur_gap[g];
        nfr[g]        <= nfr[g] + 1;
        rise_cyc[g]   <= cyc;
        rise_valid[g] <= 1'b1;
      end
      if (fd_v[g] === 1'b1) begin
        fd_cnt[g] <= fd_cnt[g] + 1;
        if (!(csn_v[g] === 1'b1 && prev_csn[g] === 1'b0)) fd_bad[g] <= fd_bad[g] + 1;
      end
      if (ovr_v[g] === 1'b1) ovr_cnt[g] <= ovr_cnt[g] + 1;
      if (ldn_v[g] === 1'b0) begin
        if (prev_ldn[g] === 1'b1) begin
          ld_cur[g] <= 1;
          ld_after[g][nld[g] % 16] <= rise_valid[g] ? (cyc - rise_cyc[g]) : -1;
        end else begin
          ld_cur[g] <= ld_cur[g] + 1;
        end
        if (csn_v[g] === 1'b0) overlap[g] <= overlap[g] + 1;
      end else if (ldn_v[g] === 1'b1 && prev_ldn[g] === 1'b0) begin
        ld_len[g][nld[g] % 16] <= ld_cur[g];
        nld[g] <= nld[g] + 1;
      end
      if ((ldn_v[g] === 1'b0 || csn_v[g] === 1'b0) && busy_v[g] !== 1'b1)
        busy_bad[g] <= busy_bad[g] + 1;
    end
  end

  // ---------------- checking helpers ----------------
  int n_err = 0;
  int n_checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] c, input logic [3:0] ch, input logic [15:0] v,
                      input logic st, input logic ld);
    dac_cmd = c; dac_channel = ch; dac_value = v;
    dac_start = st; dac_ldac = ld;
    tick();
    dac_start = 1'b0; dac_ldac = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k;
    k = 0;
    while ((a_busy !== 1'b0 || b_busy !== 1'b0) && k < budget) begin
      tick();
      k++;
    end
    tick();
    check(tag, 32'(k < budget), 32'd1);
  endtask

  task automatic rand_payload(output logic [3:0] c, output logic [3:0] ch, output logic [15:0] v);
    case ($urandom_range(0, 4))
      0: c = WRITE_N;
      1: c = UPDATE_N;
      2: c = WRITE_UPDATE_N;
      3: c = POWER_DOWN_N;
      default: c = NOP;
    endcase
    ch = ($urandom_range(0, 3) == 0) ? ADDR_ALL : 4'($urandom_range(0, 7));
    v  = 16'($urandom);
  endtask

  // Checks one reconstructed frame against its expected contents and CS timing
  task automatic check_frame(input string tag, input int d, input int idx,
                             input logic [23:0] exp_bits, input int exp_len);
    check({tag, "_bits"}, 32'(fr_bits[d][idx % 64]), 32'(exp_bits));
    check({tag, "_nsck"}, 32'(fr_nb[d][idx % 64]), 32'd24);
    check({tag, "_csnlow"}, 32'(fr_len[d][idx % 64]), 32'(exp_len));
  endtask

  logic [3:0]  c0, h0, c1, h1, c2, h2;
  logic [15:0] v0, v1, v2;
  int na, nb, fa, fb, oa, ob, la, lb, sa, sb, k;

  // ---------------- directed stimulus ----------------
  initial begin
    resetn = 1'b0;
    repeat (3) tick();
    check("rst_csn", 32'(a_csn), 32'd1);
    check("rst_sck", 32'(a_sck), 32'd0);
    check("rst_sdi", 32'(a_sdi), 32'd0);
    check("rst_ldn", 32'(a_ldn), 32'd1);
    check("rst_busy", 32'({b_busy, a_busy}), 32'd0);
    check("rst_fd", 32'({b_fd, a_fd}), 32'd0);
    check("rst_ovr", 32'({b_ovr, a_ovr}), 32'd0);
    resetn = 1'b1;
    repeat (2) tick();

    // 1: single frame 0x32ABCD on both dividers
    na = nfr[0]; nb = nfr[1]; fa = fd_cnt[0]; fb = fd_cnt[1];
    send(WRITE_UPDATE_N, 4'h2, 16'hABCD, 1'b1, 1'b0);
    check("t1_csn_fall", 32'(a_csn), 32'd0);
    check("t1_sdi_msb", 32'(a_sdi), 32'd0);
    check("t1_busy", 32'(a_busy), 32'd1);
    wait_idle("t1_idle_timeout", 1000);
    check("t1_nframes_a", 32'(nfr[0] - na), 32'd1);
    check("t1_nframes_b", 32'(nfr[1] - nb), 32'd1);
    check_frame("t1_a", 0, na, 24'h32ABCD, 49 * DIV_A);
    check_frame("t1_b", 1, nb, 24'h32ABCD, 49 * DIV_B);
    check("t1_fd_a", 32'(fd_cnt[0] - fa), 32'd1);
    check("t1_fd_b", 32'(fd_cnt[1] - fb), 32'd1);

    // 2: LDAC pulse from idle
    la = nld[0]; lb = nld[1]; na = nfall[0]; sa = busy_bad[0];
    send(4'h0, 4'h0, 16'h0, 1'b0, 1'b1);
    check("t2_ldn_low", 32'(a_ldn), 32'd0);
    check("t2_busy", 32'(a_busy), 32'd1);
    wait_idle("t2_idle_timeout", 200);
    check("t2_npulse", 32'(nld[0] - la), 32'd1);
    check("t2_width_a", 32'(ld_len[0][la % 16]), 32'(LDC));
    check("t2_width_b", 32'(ld_len[1][lb % 16]), 32'(LDC));
    check("t2_csn_quiet", 32'(nfall[0] - na), 32'd0);
    check("t2_busy_cover", 32'(busy_bad[0] - sa), 32'd0);

    // 3: two starts during a frame -> newest wins, one overrun
    rand_payload(c0, h0, v0);
    rand_payload(c1, h1, v1);
    rand_payload(c2, h2, v2);
    na = nfr[0]; nb = nfr[1]; oa = ovr_cnt[0]; ob = ovr_cnt[1];
    send(c0, h0, v0, 1'b1, 1'b0);
    send(c1, h1, 16'h1111, 1'b1, 1'b0);
    send(c2, h2, 16'h2222, 1'b1, 1'b0);
    wait_idle("t3_idle_timeout", 2000);
    check("t3_ovr_a", 32'(ovr_cnt[0] - oa), 32'd1);
    check("t3_ovr_b", 32'(ovr_cnt[1] - ob), 32'd1);
    check("t3_nframes_a", 32'(nfr[0] - na), 32'd2);
    check("t3_nframes_b", 32'(nfr[1] - nb), 32'd2);
    check_frame("t3_a0", 0, na, {c0, h0, v0}, 49 * DIV_A);
    check_frame("t3_a1", 0, na + 1, {c2, h2, 16'h2222}, 49 * DIV_A);
    check("t3_gap_a", 32'(fr_gap[0][(na + 1) % 64]), 32'(GAP));
    check_frame("t3_b1", 1, nb + 1, {c2, h2, 16'h2222}, 49 * DIV_B);
    check("t3_gap_b", 32'(fr_gap[1][(nb + 1) % 64]), 32'(GAP));

    // 4: start and ldac together -> frame, then LDAC after the gap
    rand_payload(c0, h0, v0);
    na = nfr[0]; la = nld[0]; lb = nld[1];
    send(c0, h0, v0, 1'b1, 1'b1);
    wait_idle("t4_idle_timeout", 1000);
    check_frame("t4_a", 0, na, {c0, h0, v0}, 49 * DIV_A);
    check("t4_npulse_a", 32'(nld[0] - la), 32'd1);
    check("t4_ldac_delay_a", 32'(ld_after[0][la % 16]), 32'(GAP));
    check("t4_ldac_delay_b", 32'(ld_after[1][lb % 16]), 32'(GAP));
    check("t4_width_a", 32'(ld_len[0][la % 16]), 32'(LDC));

    // 5: reset during bit 10 with a start pending
    rand_payload(c0, h0, v0);
    rand_payload(c1, h1, v1);
    fa = fd_cnt[0]; sa = fd_bad[0];
    send(c0, h0, v0, 1'b1, 1'b0);
    tick();
    k = 0;
    while (cur_nb[0] < 5 && k < 500) begin tick(); k++; end
    send(c1, h1, v1, 1'b1, 1'b0);
    while (cur_nb[0] < 14 && k < 1000) begin tick(); k++; end
    check("t5_reach_bit10", 32'(cur_nb[0]), 32'd14);
    resetn = 1'b0;
    tick();
    check("t5_csn", 32'(a_csn), 32'd1);
    check("t5_sck", 32'(a_sck), 32'd0);
    check("t5_busy", 32'(a_busy), 32'd0);
    check("t5_fd_now", 32'(a_fd), 32'd0);
    resetn = 1'b1;
    na = nfall[0];
    repeat (300) tick();
    check("t5_pending_dropped", 32'(nfall[0] - na), 32'd0);
    check("t5_no_frame_done", 32'(fd_cnt[0] - fa), 32'd0);
    check("t5_fd_placement", 32'(fd_bad[0] - sa), 32'd0);
    check("t5_still_idle", 32'(a_busy), 32'd0);

    // 6: CLK_DIV=1, back-to-back pending starts, random payloads
    for (int r = 0; r < 3; r++) begin
      rand_payload(c0, h0, v0);
      rand_payload(c1, h1, v1);
      rand_payload(c2, h2, v2);
      nb = nfr[1]; ob = ovr_cnt[1];
      send(c0, h0, v0, 1'b1, 1'b0);
      send(c1, h1, v1, 1'b1, 1'b0);
      k = 0;
      while (nfr[1] < nb + 1 && k < 500) begin tick(); k++; end
      while (b_csn !== 1'b0 && k < 500) begin tick(); k++; end
      check("t6_second_frame_started", 32'(k < 500), 32'd1);
      send(c2, h2, v2, 1'b1, 1'b0);
      wait_idle("t6_idle_timeout", 2000);
      check("t6_nframes", 32'(nfr[1] - nb), 32'd3);
      check("t6_no_ovr", 32'(ovr_cnt[1] - ob), 32'd0);
      check_frame("t6_f0", 1, nb, {c0, h0, v0}, 49 * DIV_B);
      check_frame("t6_f1", 1, nb + 1, {c1, h1, v1}, 49 * DIV_B);
      check_frame("t6_f2", 1, nb + 2, {c2, h2, v2}, 49 * DIV_B);
      check("t6_gap1", 32'(fr_gap[1][(nb + 1) % 64]), 32'(GAP));
      check("t6_gap2", 32'(fr_gap[1][(nb + 2) % 64]), 32'(GAP));
    end

    // whole-run invariants
    check("ldac_csn_overlap_a", 32'(overlap[0]), 32'd0);
    check("ldac_csn_overlap_b", 32'(overlap[1]), 32'd0);
    check("fd_placement_b", 32'(fd_bad[1]), 32'd0);
    check("busy_cover_b", 32'(busy_bad[1]), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
